// File: rtl/tb_tohost_mailbox_if.sv
// ---------------------------------------------------------------------------
// tb_tohost_mailbox_if
//
// Purpose: ICB command/response bundle between a bus master (the core's
// spare peripheral port, or a bench driver) and the tohost mailbox.
//
// Signals:
//   i_icb_cmd_valid / i_icb_cmd_ready   command handshake
//   i_icb_cmd_addr   [ADDR_W-1:0]       byte offset inside the mailbox window
//   i_icb_cmd_read                      1 = read, 0 = write
//   i_icb_cmd_wdata  [31:0]             write data
//   i_icb_cmd_wmask  [3:0]              byte enables
//   i_icb_rsp_valid / i_icb_rsp_ready   response handshake
//   i_icb_rsp_err                       response error
//   i_icb_rsp_rdata  [31:0]             read data
//
// Modports: master drives the command and rsp_ready; slave drives the rest.
// ---------------------------------------------------------------------------
interface tb_tohost_mailbox_if #(
    parameter int ADDR_W = 12
) ();
    logic              i_icb_cmd_valid;
    logic              i_icb_cmd_ready;
    logic [ADDR_W-1:0] i_icb_cmd_addr;
    logic              i_icb_cmd_read;
    logic [31:0]       i_icb_cmd_wdata;
    logic [3:0]        i_icb_cmd_wmask;
    logic              i_icb_rsp_valid;
    logic              i_icb_rsp_ready;
    logic              i_icb_rsp_err;
    logic [31:0]       i_icb_rsp_rdata;

    modport master (
        output i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read,
               i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_rsp_ready,
        input  i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err,
               i_icb_rsp_rdata
    );

    modport slave (
        input  i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read,
               i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_rsp_ready,
        output i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err,
               i_icb_rsp_rdata
    );
endinterface

// File: rtl/tb_tohost_mailbox.sv
// ---------------------------------------------------------------------------
// tb_tohost_mailbox
//
// Purpose: ICB responder that test software writes to in order to report
// completion (tohost), request stimulus interrupts and read the cycle time.
// One outstanding transaction, response latency 1, side effects at command
// acceptance.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   bus            tb_tohost_mailbox_if.slave ICB port
//   irq_ext_o      requested external interrupt level
//   irq_sft_o      requested software interrupt level
//   irq_tmr_o      requested timer interrupt level
//   done_o         sticky, test finished
//   pass_o         meaningful while done_o=1; 1 = first end value was 1
//   timeout_o      sticky watchdog expiry
//
// Register map (word offset = addr[ADDR_W-1:2]):
//   0x00 TOHOST  0x04 FROMHOST  0x08 CYCLE (RO)  0x0C STATUS (RO)
//   0x10 IRQ_SET (W1S)  0x14 IRQ_CLR (W1C)
//
// Build option: define MAILBOX_WDOG_EN to enable the watchdog; when it is
// undefined timeout_o is tied low and STATUS[2] reads 0.
// ---------------------------------------------------------------------------
module tb_tohost_mailbox #(
    parameter int ADDR_W    = 12,
    parameter int CNT_W     = 32,
    parameter int WDOG_LOG2 = 20
) (
    input  logic               clk,
    input  logic               rst,
    tb_tohost_mailbox_if.slave bus,
    output logic               irq_ext_o,
    output logic               irq_sft_o,
    output logic               irq_tmr_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o
);

    localparam int OFF_W = ADDR_W - 2;
    localparam logic [OFF_W-1:0] OFF_TOHOST   = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_FROMHOST = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_CYCLE    = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_STATUS   = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_IRQ_SET  = OFF_W'(4);
    localparam logic [OFF_W-1:0] OFF_IRQ_CLR  = OFF_W'(5);

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    state_t           state, state_nxt;
    logic [OFF_W-1:0] off;
    logic             accept;
    logic             wr_en;
    logic [31:0]      rd_data;
    logic             acc_err;
    logic [31:0]      tohost_wr;
    logic [2:0]       irq_bits;

    logic [31:0]      tohost;
    logic [31:0]      fromhost;
    logic             done;
    logic             pass;
    logic [7:0]       end_cnt;
    logic [2:0]       irq;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rsp_err_p1;
    logic [31:0]      rsp_rdata_p1;

    function automatic logic [31:0] apply_mask(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  wm);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wm[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // -------- handshake FSM --------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.i_icb_cmd_valid) state_nxt = ST_RESP;
            ST_RESP: if (bus.i_icb_rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.i_icb_cmd_ready = (state == ST_IDLE);
    assign bus.i_icb_rsp_valid = (state == ST_RESP);
    assign accept = bus.i_icb_cmd_valid & bus.i_icb_cmd_ready;
    assign off    = bus.i_icb_cmd_addr[ADDR_W-1:2];
    // A zero byte mask is a legal no-op write, so it never touches state.
    assign wr_en  = accept & ~bus.i_icb_cmd_read & (bus.i_icb_cmd_wmask != 4'd0);

    assign tohost_wr = apply_mask(tohost, bus.i_icb_cmd_wdata, bus.i_icb_cmd_wmask);
    // W1S/W1C bits all live in byte 0, so only wmask[0] can enable them.
    assign irq_bits  = bus.i_icb_cmd_wdata[2:0] & {3{bus.i_icb_cmd_wmask[0]}};

    // -------- p0: decode at acceptance --------
    // Writes always return zero read data.
    always_comb begin
        rd_data = 32'd0;
        acc_err = 1'b0;
        case (off)
            OFF_TOHOST:   rd_data = tohost;
            OFF_FROMHOST: rd_data = fromhost;
            OFF_CYCLE: begin
                rd_data = 32'(cycle_cnt);
                acc_err = ~bus.i_icb_cmd_read;
            end
            OFF_STATUS: begin
                rd_data = {16'd0, end_cnt, 5'd0, timeout, pass, done};
                acc_err = ~bus.i_icb_cmd_read;
            end
            OFF_IRQ_SET:  rd_data = {29'd0, irq};
            OFF_IRQ_CLR:  rd_data = 32'd0;
            default:      acc_err = 1'b1;
        endcase
        if (!bus.i_icb_cmd_read) rd_data = 32'd0;
    end

    // -------- p1: response registers --------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_p1   <= 1'b0;
            rsp_rdata_p1 <= 32'd0;
        end else if (accept) begin
            rsp_err_p1   <= acc_err;
            rsp_rdata_p1 <= rd_data;
        end
    end

    assign bus.i_icb_rsp_err   = rsp_err_p1;
    assign bus.i_icb_rsp_rdata = rsp_rdata_p1;

    // Register side effects. TOHOST freezes once the first end value
    // (bit0=1) lands; every end write, first included, bumps END_CNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tohost   <= 32'd0;
            fromhost <= 32'd0;
            done     <= 1'b0;
            pass     <= 1'b0;
            end_cnt  <= 8'd0;
            irq      <= 3'd0;
        end else if (wr_en) begin
            case (off)
                OFF_TOHOST: begin
                    if (!done) begin
                        tohost <= tohost_wr;
                        if (tohost_wr[0]) begin
                            done    <= 1'b1;
                            pass    <= (tohost_wr == 32'h1);
                            end_cnt <= sat_inc(end_cnt);
                        end
                    end else if (tohost_wr[0]) begin
                        end_cnt <= sat_inc(end_cnt);
                    end
                end
                OFF_FROMHOST: fromhost <= apply_mask(fromhost, bus.i_icb_cmd_wdata,
                                                     bus.i_icb_cmd_wmask);
                OFF_IRQ_SET:  irq <= irq | irq_bits;
                OFF_IRQ_CLR:  irq <= irq & ~irq_bits;
                default: ;
            endcase
        end
    end

    assign cnt_nxt = cycle_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cnt_nxt;
    end

`ifdef MAILBOX_WDOG_EN
    // Raised on the same edge the counter reaches 2^WDOG_LOG2, so timeout_o
    // is visible in the first cycle the counter bit reads 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             timeout <= 1'b0;
        else if (cnt_nxt[WDOG_LOG2] && !done) timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign irq_ext_o = irq[0];
    assign irq_sft_o = irq[1];
    assign irq_tmr_o = irq[2];
    assign done_o    = done;
    assign pass_o    = pass;
    assign timeout_o = timeout;

endmodule

// File: tb/tb_tb_tohost_mailbox.sv
// ---------------------------------------------------------------------------
// tb_tb_tohost_mailbox
//
// Purpose: self-checking bench for tb_tohost_mailbox. A transaction-level
// model of the mailbox tracks the expected outputs; a monitor compares the
// DUT against it every cycle, and directed steps pin literal values.
// The DUT runs with WDOG_LOG2=4; build with MAILBOX_WDOG_EN to exercise the
// watchdog.
// ---------------------------------------------------------------------------
module tb_tb_tohost_mailbox;

    localparam int W = 4;
`ifdef MAILBOX_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq_ext, irq_sft, irq_tmr, done, pass, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    tb_tohost_mailbox_if #(.ADDR_W(12)) bus ();

    tb_tohost_mailbox #(.ADDR_W(12), .CNT_W(32), .WDOG_LOG2(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .irq_ext_o (irq_ext),
        .irq_sft_o (irq_sft),
        .irq_tmr_o (irq_tmr),
        .done_o    (done),
        .pass_o    (pass),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] m_tohost = 0, m_fromhost = 0, m_cycle = 0, m_rdata = 0;
    logic [2:0]  m_irq = 0;
    bit          m_done = 0, m_pass = 0, m_timeout = 0, m_pending = 0, m_err = 0;
    int          m_endcnt = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wm);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic m_accept();
        int          word = int'(bus.i_icb_cmd_addr >> 2);
        bit          rd   = bus.i_icb_cmd_read;
        bit          wr   = !rd && (bus.i_icb_cmd_wmask != 0);
        logic [31:0] wd   = bus.i_icb_cmd_wdata;
        logic [2:0]  bits = wd[2:0] & {3{bus.i_icb_cmd_wmask[0]}};
        logic [31:0] v;
        m_err = 0;
        m_rdata = 0;
        case (word)
            0: if (rd) m_rdata = m_tohost;
               else if (wr) begin
                   v = merge(m_tohost, wd, bus.i_icb_cmd_wmask);
                   if (!m_done) m_tohost = v;
                   if (v[0]) begin
                       if (!m_done) begin m_done = 1; m_pass = (v == 32'h1); end
                       if (m_endcnt < 255) m_endcnt++;
                   end
               end
            1: if (rd) m_rdata = m_fromhost;
               else if (wr) m_fromhost = merge(m_fromhost, wd, bus.i_icb_cmd_wmask);
            2: if (rd) m_rdata = m_cycle; else m_err = 1;
            3: if (rd) m_rdata = m_endcnt * 256 + 4 * m_timeout + 2 * m_pass + m_done;
               else m_err = 1;
            4: if (rd) m_rdata = {29'd0, m_irq}; else if (wr) m_irq = m_irq | bits;
            5: if (wr) m_irq = m_irq & ~bits;
            default: m_err = 1;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_tohost = 0; m_fromhost = 0; m_cycle = 0; m_rdata = 0; m_irq = 0;
                m_done = 0; m_pass = 0; m_timeout = 0; m_pending = 0; m_err = 0;
                m_endcnt = 0;
            end else begin
                bit prev_done = m_done;
                if (m_pending) begin
                    if (bus.i_icb_rsp_ready) m_pending = 0;
                end else if (bus.i_icb_cmd_valid) begin
                    m_accept();
                    m_pending = 1;
                end
                m_cycle = m_cycle + 1;
                if (WD_EN && m_cycle[W] && !prev_done) m_timeout = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cmd_ready", 32'(bus.i_icb_cmd_ready), 32'(!m_pending));
        chk("rsp_valid", 32'(bus.i_icb_rsp_valid), 32'(m_pending));
        chk("irq", {29'd0, irq_tmr, irq_sft, irq_ext}, {29'd0, m_irq});
        chk("done", 32'(done), 32'(m_done));
        chk("timeout", 32'(timeout), 32'(m_timeout));
        if (m_done) chk("pass", 32'(pass), 32'(m_pass));
        if (m_pending) begin
            chk("rsp_err", 32'(bus.i_icb_rsp_err), 32'(m_err));
            chk("rsp_rdata", bus.i_icb_rsp_rdata, m_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input bit rd, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, input int hold,
                       output logic [31:0] rdata, output logic err);
        int n = 0;
        bus.i_icb_cmd_valid = 1'b1;
        bus.i_icb_cmd_read  = rd;
        bus.i_icb_cmd_addr  = a;
        bus.i_icb_cmd_wdata = wd;
        bus.i_icb_cmd_wmask = wm;
        bus.i_icb_rsp_ready = 1'b0;
        @(negedge clk);
        while (!bus.i_icb_cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("cmd_ready_wait", 32'(bus.i_icb_cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_icb_cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.i_icb_rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rsp_valid_wait", 32'(bus.i_icb_rsp_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_rsp_valid", 32'(bus.i_icb_rsp_valid), 32'd1);
            chk("hold_cmd_ready", 32'(bus.i_icb_cmd_ready), 32'd0);
            @(negedge clk);
        end
        rdata = bus.i_icb_rsp_rdata;
        err   = bus.i_icb_rsp_err;
        bus.i_icb_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_icb_rsp_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        bus.i_icb_cmd_valid = 1'b0;
        bus.i_icb_cmd_read  = 1'b0;
        bus.i_icb_cmd_addr  = '0;
        bus.i_icb_cmd_wdata = '0;
        bus.i_icb_cmd_wmask = '0;
        bus.i_icb_rsp_ready = 1'b0;

        // reset values, then CYCLE read 10 edges after release
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.i_icb_cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.i_icb_rsp_valid), 32'd0);
        chk("rst_outputs", {26'd0, irq_ext, irq_sft, irq_tmr, done, pass, timeout}, 32'd0);
        chk("rst_rdata", bus.i_icb_rsp_rdata, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        txn(1, 12'h008, 0, 0, 0, rd, er);
        chk("cycle_at_10", rd, 32'd10);
        chk("cycle_err", 32'(er), 32'd0);

        // watchdog with no TOHOST write
        do_reset(3);
        repeat (15) @(posedge clk); #1;
        chk("wdog_cycle15", 32'(timeout), 32'd0);
        @(posedge clk); #1;
        chk("wdog_cycle16", 32'(timeout), 32'(WD_EN));
        repeat (10) @(posedge clk); #1;
        chk("wdog_sticky", 32'(timeout), 32'(WD_EN));

        // pass flow, TOHOST accepted on the 5th edge; watchdog must stay low
        do_reset(3);
        repeat (4) @(posedge clk); #1;
        txn(0, 12'h000, 32'h1, 4'hF, 0, rd, er);
        chk("pass_err", 32'(er), 32'd0);
        chk("pass_done", 32'(done), 32'd1);
        chk("pass_pass", 32'(pass), 32'd1);
        txn(1, 12'h00C, 0, 0, 0, rd, er);
        chk("pass_status", rd, 32'h0000_0103);
        repeat (30) @(posedge clk); #1;
        chk("pass_no_timeout", 32'(timeout), 32'd0);

        // fail value then a later pass value
        do_reset(2);
        txn(0, 12'h000, 32'h7, 4'hF, 0, rd, er);
        chk("fail_done", 32'(done), 32'd1);
        chk("fail_pass", 32'(pass), 32'd0);
        txn(0, 12'h000, 32'h1, 4'hF, 0, rd, er);
        chk("repeat_pass", 32'(pass), 32'd0);
        txn(1, 12'h00C, 0, 0, 0, rd, er);
        chk("repeat_status", rd, 32'h0000_0201);
        txn(1, 12'h000, 0, 0, 0, rd, er);
        chk("tohost_frozen", rd, 32'h7);

        // backpressure and byte-masked scratch
        txn(0, 12'h004, 32'hA5A5_0000, 4'hF, 5, rd, er);
        txn(0, 12'h004, 32'h0000_0012, 4'h1, 0, rd, er);
        txn(1, 12'h004, 0, 0, 0, rd, er);
        chk("fromhost_mask", rd, 32'hA5A5_0012);

        // interrupts, error responses, no-op writes
        txn(0, 12'h010, 32'h5, 4'hF, 0, rd, er);
        chk("irq_set", {29'd0, irq_tmr, irq_sft, irq_ext}, 32'b101);
        txn(1, 12'h010, 0, 0, 0, rd, er);
        chk("irq_set_read", rd, 32'h5);
        txn(0, 12'h014, 32'h1, 4'hF, 0, rd, er);
        chk("irq_clr", {29'd0, irq_tmr, irq_sft, irq_ext}, 32'b100);
        txn(1, 12'h014, 0, 0, 0, rd, er);
        chk("irq_clr_read", {rd[30:0], er}, 32'd0);
        txn(0, 12'h008, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
        chk("ro_write_err", 32'(er), 32'd1);
        txn(1, 12'h040, 0, 0, 0, rd, er);
        chk("unmapped_rd_err", 32'(er), 32'd1);
        chk("unmapped_rdata", rd, 32'd0);
        txn(0, 12'h040, 32'h3, 4'hF, 0, rd, er);
        chk("unmapped_wr_err", 32'(er), 32'd1);
        txn(1, 12'h010, 0, 0, 0, rd, er);
        chk("irq_unchanged", rd, 32'h4);
        txn(0, 12'h004, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
        chk("wmask0_err", 32'(er), 32'd0);
        txn(1, 12'h006, 0, 0, 0, rd, er);
        chk("wmask0_nochange", rd, 32'hA5A5_0012);

        // reset while a response is pending
        bus.i_icb_cmd_valid = 1'b1;
        bus.i_icb_cmd_read  = 1'b0;
        bus.i_icb_cmd_addr  = 12'h004;
        bus.i_icb_cmd_wdata = 32'hDEAD_BEEF;
        bus.i_icb_cmd_wmask = 4'hF;
        @(posedge clk); #1;
        bus.i_icb_cmd_valid = 1'b0;
        @(negedge clk);
        chk("midrst_pending", 32'(bus.i_icb_rsp_valid), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(bus.i_icb_rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(bus.i_icb_cmd_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        txn(1, 12'h004, 0, 0, 0, rd, er);
        chk("midrst_fromhost", rd, 32'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
